// File: rtl/obj_coord_fetcher_pkg.sv
// Shared definitions for the object coordinate fetcher.
// Contents: FSM state encoding and the default location/spacing of the
// coordinate table in memory.
package obj_coord_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Address of object 0's X word and the step between consecutive words.
  localparam int OCF_BASE_ADDR = 6000;
  localparam int OCF_STRIDE    = 4;

endpackage

// File: rtl/obj_coord_fetcher_fetch_tag_pipe.sv
// fetch_tag_pipe: DEPTH-stage delay line carrying a word index and its valid
// bit. It tracks each issued read address so that the returning data word
// can be steered into the right shadow register.
// Ports:
//   clk, reset        - clock, synchronous active-high reset (clears all tags)
//   in_vld, in_idx    - tag for the address presented this cycle
//   out_vld, out_idx  - the same tag, DEPTH cycles later
module fetch_tag_pipe
  import obj_coord_fetcher_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [IDX_W-1:0] idx_d [DEPTH];

  always_comb begin
    vld_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_d[i] = '0;
    end
    vld_d[0] = in_vld;
    idx_d[0] = in_idx;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  // Clearing the tags on reset is what stops data already in flight from
  // being written into the shadow registers after an aborted sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/obj_coord_fetcher.sv
// obj_coord_fetcher: on frame_start, sweeps the 2*NUM_OBJ coordinate words
// (X0,Y0,X1,Y1,...) out of a read-only memory into shadow registers, then
// copies them all to obj_x/obj_y in one cycle so no partial update is seen.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   frame_start    - request a refresh (honoured only in IDLE)
//   mem_addr       - read address; mem_data returns READ_LAT cycles later
//   mem_data       - read data
//   obj_x, obj_y   - packed coordinates, object i at [i*WIDTH +: WIDTH]
//   coords_valid   - at least one refresh has been committed
//   busy           - sweep in progress (FETCH, DRAIN, COMMIT)
//   update_done    - one-cycle pulse when obj_x/obj_y take new values
//   overrun        - sticky: frame_start arrived while busy
module obj_coord_fetcher
  import obj_coord_fetcher_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16,
  parameter int NUM_OBJ   = 3,
  parameter int BASE_ADDR = OCF_BASE_ADDR,
  parameter int STRIDE    = OCF_STRIDE,
  parameter int READ_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  output logic [ADDR_BITS-1:0]     mem_addr,
  input  logic [WIDTH-1:0]         mem_data,
  output logic [NUM_OBJ*WIDTH-1:0] obj_x,
  output logic [NUM_OBJ*WIDTH-1:0] obj_y,
  output logic                     coords_valid,
  output logic                     busy,
  output logic                     update_done,
  output logic                     overrun
);

  localparam int NWORDS = 2 * NUM_OBJ;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NWORDS - 1);
  localparam logic [1:0]       LAST_DRAIN = 2'(READ_LAT - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [1:0]               drain_q, drain_d;
  logic [WIDTH-1:0]         shadow_q [NWORDS];
  logic [WIDTH-1:0]         shadow_d [NWORDS];
  logic [NUM_OBJ*WIDTH-1:0] obj_x_q, obj_x_d;
  logic [NUM_OBJ*WIDTH-1:0] obj_y_q, obj_y_d;
  logic                     coords_valid_q, coords_valid_d;
  logic                     update_done_q, update_done_d;
  logic                     overrun_q, overrun_d;

  logic                     tag_vld;
  logic [IDX_W-1:0]         tag_idx;

  fetch_tag_pipe #(
    .DEPTH (READ_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (state_q == ST_FETCH),
    .in_idx  (idx_q),
    .out_vld (tag_vld),
    .out_idx (tag_idx)
  );

  // Next-state logic: one word per FETCH cycle, then READ_LAT DRAIN cycles so
  // the last word lands before COMMIT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
        end
      end
      ST_FETCH: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d = ST_COMMIT;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Address arithmetic is done in int and truncated, giving the modulo
  // 2^ADDR_BITS wrap for tables that straddle the top of the address space.
  always_comb begin
    mem_addr = ADDR_BITS'(BASE_ADDR);
    if (state_q == ST_FETCH) begin
      mem_addr = ADDR_BITS'(BASE_ADDR + int'(idx_q) * STRIDE);
    end
  end

  always_comb begin
    shadow_d       = shadow_q;
    obj_x_d        = obj_x_q;
    obj_y_d        = obj_y_q;
    coords_valid_d = coords_valid_q;
    update_done_d  = 1'b0;
    overrun_d      = overrun_q | (frame_start && (state_q != ST_IDLE));

    if (tag_vld) begin
      shadow_d[tag_idx] = mem_data;
    end

    // Even words are X, odd words are Y.
    if (state_q == ST_COMMIT) begin
      for (int o = 0; o < NUM_OBJ; o++) begin
        obj_x_d[o*WIDTH +: WIDTH] = shadow_q[2*o];
        obj_y_d[o*WIDTH +: WIDTH] = shadow_q[2*o+1];
      end
      coords_valid_d = 1'b1;
      update_done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      drain_q        <= '0;
      obj_x_q        <= '0;
      obj_y_q        <= '0;
      coords_valid_q <= 1'b0;
      update_done_q  <= 1'b0;
      overrun_q      <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      drain_q        <= drain_d;
      obj_x_q        <= obj_x_d;
      obj_y_q        <= obj_y_d;
      coords_valid_q <= coords_valid_d;
      update_done_q  <= update_done_d;
      overrun_q      <= overrun_d;
      shadow_q       <= shadow_d;
    end
  end

  assign obj_x        = obj_x_q;
  assign obj_y        = obj_y_q;
  assign coords_valid = coords_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign update_done  = update_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_obj_coord_fetcher.sv
// Testbench for obj_coord_fetcher: a default instance (a) and a generalised
// instance (b: NUM_OBJ=5, STRIDE=2, READ_LAT=2, BASE_ADDR=16'hFFF8).
// Stimulus pushes expected commits into per-instance queues; monitors pop
// and compare on every update_done and otherwise require the outputs to hold.
module tb_obj_coord_fetcher;

  typedef struct {
    logic [79:0] x;
    logic [79:0] y;
    int          start;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Instance a (defaults)
  logic        reset_a, frame_start_a;
  logic [15:0] mem_addr_a, mem_data_a;
  logic [47:0] obj_x_a, obj_y_a;
  logic        coords_valid_a, busy_a, update_done_a, overrun_a;

  // Instance b (generalised)
  logic        reset_b, frame_start_b;
  logic [15:0] mem_addr_b, mem_data_b;
  logic [79:0] obj_x_b, obj_y_b;
  logic        coords_valid_b, busy_b, update_done_b, overrun_b;

  obj_coord_fetcher dut_a (
    .clk          (clk),
    .reset        (reset_a),
    .frame_start  (frame_start_a),
    .mem_addr     (mem_addr_a),
    .mem_data     (mem_data_a),
    .obj_x        (obj_x_a),
    .obj_y        (obj_y_a),
    .coords_valid (coords_valid_a),
    .busy         (busy_a),
    .update_done  (update_done_a),
    .overrun      (overrun_a)
  );

  obj_coord_fetcher #(
    .WIDTH     (16),
    .ADDR_BITS (16),
    .NUM_OBJ   (5),
    .BASE_ADDR (16'hFFF8),
    .STRIDE    (2),
    .READ_LAT  (2)
  ) dut_b (
    .clk          (clk),
    .reset        (reset_b),
    .frame_start  (frame_start_b),
    .mem_addr     (mem_addr_b),
    .mem_data     (mem_data_b),
    .obj_x        (obj_x_b),
    .obj_y        (obj_y_b),
    .coords_valid (coords_valid_b),
    .busy         (busy_b),
    .update_done  (update_done_b),
    .overrun      (overrun_b)
  );

  // Memory models: latency 1 for a, latency 2 for b.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] rd_a, rd_b1, rd_b2;

  always @(posedge clk) begin
    rd_a  <= mem_a[mem_addr_a];
    rd_b1 <= mem_b[mem_addr_b];
    rd_b2 <= rd_b1;
    cyc   <= cyc + 1;
  end
  assign mem_data_a = rd_a;
  assign mem_data_b = rd_b2;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: sample 1 time unit after the active edge.
  logic [79:0] prev_xa = '0, prev_ya = '0, prev_xb = '0, prev_yb = '0;
  exp_t ea, eb;

  always @(posedge clk) begin
    #1;
    if (reset_a) begin
      prev_xa = 80'(obj_x_a);
      prev_ya = 80'(obj_y_a);
    end else if (update_done_a) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_update actual=1 required=0");
      end else begin
        ea = qa.pop_front();
        chk("a_obj_x", 80'(obj_x_a), ea.x);
        chk("a_obj_y", 80'(obj_y_a), ea.y);
        chk("a_coords_valid", 80'(coords_valid_a), 80'(1));
        chk("a_latency", 80'(cyc - ea.start), 80'(ea.lat));
      end
      prev_xa = 80'(obj_x_a);
      prev_ya = 80'(obj_y_a);
    end else begin
      chk("a_hold_x", 80'(obj_x_a), prev_xa);
      chk("a_hold_y", 80'(obj_y_a), prev_ya);
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset_b) begin
      prev_xb = obj_x_b;
      prev_yb = obj_y_b;
    end else if (update_done_b) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_update actual=1 required=0");
      end else begin
        eb = qb.pop_front();
        chk("b_obj_x", obj_x_b, eb.x);
        chk("b_obj_y", obj_y_b, eb.y);
        chk("b_coords_valid", 80'(coords_valid_b), 80'(1));
        chk("b_latency", 80'(cyc - eb.start), 80'(eb.lat));
      end
      prev_xb = obj_x_b;
      prev_yb = obj_y_b;
    end else begin
      chk("b_hold_x", obj_x_b, prev_xb);
      chk("b_hold_y", obj_y_b, prev_yb);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse frame_start for one cycle; optionally record the expected commit.
  task automatic fs_a(input logic push, input logic [79:0] x, input logic [79:0] y);
    exp_t e;
    frame_start_a = 1'b1;
    if (push) begin
      e.x = x; e.y = y; e.start = cyc + 1; e.lat = 8;
      qa.push_back(e);
    end
    @(negedge clk);
    frame_start_a = 1'b0;
  endtask

  task automatic fs_b(input logic [79:0] x, input logic [79:0] y);
    exp_t e;
    frame_start_b = 1'b1;
    e.x = x; e.y = y; e.start = cyc + 1; e.lat = 13;
    qb.push_back(e);
    @(negedge clk);
    frame_start_b = 1'b0;
  endtask

  localparam logic [79:0] XA1 = {32'd0, 16'd50, 16'd30, 16'd10};
  localparam logic [79:0] YA1 = {32'd0, 16'd60, 16'd40, 16'd20};
  localparam logic [79:0] XA2 = {32'd0, 16'd50, 16'd77, 16'd10};
  localparam logic [79:0] XA3 = {32'd0, 16'd50, 16'd77, 16'd99};
  localparam logic [79:0] YA4 = {32'd0, 16'd60, 16'd40, 16'd21};
  localparam logic [79:0] XB  = {16'h0108, 16'h0106, 16'h0104, 16'h0102, 16'h0100};
  localparam logic [79:0] YB  = {16'h0109, 16'h0107, 16'h0105, 16'h0103, 16'h0101};

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int k = 0; k < 6; k++) mem_a[6000 + 4*k] = 16'(10 * (k + 1));
    a = 16'hFFF8;
    for (int k = 0; k < 10; k++) begin
      mem_b[a] = 16'(16'h0100 + k);
      a = a + 16'd2;
    end

    // Reset with a simultaneous frame_start: reset must win.
    reset_a = 1'b1; frame_start_a = 1'b1;
    reset_b = 1'b1; frame_start_b = 1'b0;
    tick(3);
    chk("a_rst_obj_x", 80'(obj_x_a), '0);
    chk("a_rst_obj_y", 80'(obj_y_a), '0);
    chk("a_rst_coords_valid", 80'(coords_valid_a), '0);
    chk("a_rst_busy", 80'(busy_a), '0);
    chk("a_rst_update_done", 80'(update_done_a), '0);
    chk("a_rst_overrun", 80'(overrun_a), '0);
    reset_a = 1'b0; frame_start_a = 1'b0;
    tick(2);
    chk("a_idle_busy", 80'(busy_a), '0);

    // Basic sweep
    fs_a(1'b1, XA1, YA1);
    chk("a_busy_fetch", 80'(busy_a), 80'(1));
    tick(12);
    chk("a_cv_after_1", 80'(coords_valid_a), 80'(1));
    chk("a_busy_after_1", 80'(busy_a), '0);
    chk("a_overrun_after_1", 80'(overrun_a), '0);

    // Memory changes mid-sweep: word 6008 changed before, 6000 after its read
    mem_a[6008] = 16'd77;
    fs_a(1'b1, XA2, YA1);
    tick(1);
    mem_a[6000] = 16'd99;
    tick(12);

    // Back-to-back: second request ignored, then one accepted right after COMMIT
    fs_a(1'b1, XA3, YA1);
    tick(2);
    fs_a(1'b0, '0, '0);
    for (int i = 0; i < 30 && !update_done_a; i++) @(negedge clk);
    chk("a_wait_update", 80'(update_done_a), 80'(1));
    mem_a[6004] = 16'd21;
    fs_a(1'b1, XA3, YA4);
    chk("a_overrun_set", 80'(overrun_a), 80'(1));
    chk("a_busy_after_idle_req", 80'(busy_a), 80'(1));
    tick(12);

    // Reset during FETCH k=3: sweep discarded
    fs_a(1'b0, '0, '0);
    tick(3);
    reset_a = 1'b1;
    tick(1);
    reset_a = 1'b0;
    chk("a_midrst_obj_x", 80'(obj_x_a), '0);
    chk("a_midrst_obj_y", 80'(obj_y_a), '0);
    chk("a_midrst_cv", 80'(coords_valid_a), '0);
    chk("a_midrst_overrun", 80'(overrun_a), '0);
    chk("a_midrst_busy", 80'(busy_a), '0);
    tick(10);
    chk("a_midrst_cv_later", 80'(coords_valid_a), '0);
    fs_a(1'b1, XA3, YA4);
    tick(12);
    chk("a_cv_after_rst", 80'(coords_valid_a), 80'(1));

    // Generalised configuration with address wrap
    reset_b = 1'b0;
    tick(1);
    chk("b_rst_obj_x", obj_x_b, '0);
    chk("b_rst_cv", 80'(coords_valid_b), '0);
    chk("b_rst_busy", 80'(busy_b), '0);
    fs_b(XB, YB);
    chk("b_busy_fetch", 80'(busy_b), 80'(1));
    tick(18);
    chk("b_cv_after", 80'(coords_valid_b), 80'(1));
    chk("b_busy_after", 80'(busy_b), '0);
    chk("b_overrun", 80'(overrun_b), '0);

    tick(3);
    chk("a_pending", 80'(qa.size()), '0);
    chk("b_pending", 80'(qb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
